register_file: RTL

//   RISC-V integer register file; sink of the write-back stage's (value, enable, rd) interface.

---
 rtl/register_file_if.sv | 28 ++
 rtl/register_file.sv | 67 ++++++
 2 files changed

// File: rtl/register_file_if.sv
// Bus between write-back/decode and the integer register file: write side,
// two combinational read ports, the debug read port and the commit counter.
interface register_file_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 32
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [XLEN-1:0]  wr_data;
    logic [AW-1:0]    rs1_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [AW-1:0]    rs2_addr;
    logic [XLEN-1:0]  rs2_data;
    logic [AW-1:0]    dbg_addr;
    logic [XLEN-1:0]  dbg_data;
    logic [CNT_W-1:0] wr_count;

    modport master (
        output wr_en, wr_addr, wr_data, rs1_addr, rs2_addr, dbg_addr,
        input  rs1_data, rs2_data, dbg_data, wr_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rs1_addr, rs2_addr, dbg_addr,
        output rs1_data, rs2_data, dbg_data, wr_count
    );
endinterface

// File: rtl/register_file.sv
// RISC-V integer register file: x0 hard-wired to zero, two combinational read
// ports with write-through bypass, registered debug read, wrapping commit count.
module register_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    register_file_if.slave rf
);

    logic [XLEN-1:0] regs [NREGS];
    logic            commit;

    assign commit = rf.wr_en && (rf.wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[rf.wr_addr] <= rf.wr_data;
        end
    end

    // Bypass is suppressed in reset so nothing leaks through while the array is held clear.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (rst_n && (addr != '0)) begin
            if (rf.wr_en && (rf.wr_addr == addr)) begin
                val = rf.wr_data;
            end else begin
                val = regs[addr];
            end
        end
        return val;
    endfunction

    always_comb begin
        rf.rs1_data = read_port(rf.rs1_addr);
        rf.rs2_data = read_port(rf.rs2_addr);
    end

    // Debug port deliberately sees the pre-write contents (no bypass).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf.dbg_data <= '0;
        end else if (rf.dbg_addr == '0) begin
            rf.dbg_data <= '0;
        end else begin
            rf.dbg_data <= regs[rf.dbg_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf.wr_count <= '0;
        end else if (commit) begin
            rf.wr_count <= rf.wr_count + CNT_W'(1);
        end
    end

endmodule
